// File: rtl/wimax_pkg.sv
// rtl/wimax_pkg.sv - shared constants, state type and parity helper for the FEC encoder
// Contents: block/output sizes, constraint length, generator polynomials,
//           fec_state_t read-side FSM encoding, fec_parity() tap reduction.
package wimax_pkg;

    localparam int FEC_BLOCK_BITS = 96;
    localparam int FEC_OUT_BITS   = 192;
    localparam int FEC_K          = 7;

    // Generator taps ordered {b, s1, s2, s3, s4, s5, s6}, MSB = current input bit
    localparam logic [FEC_K-1:0] FEC_G1 = 7'o171;
    localparam logic [FEC_K-1:0] FEC_G2 = 7'o133;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ENC  = 2'd2
    } fec_state_t;

    function automatic logic fec_parity(input logic [FEC_K-1:0] taps,
                                        input logic [FEC_K-1:0] gen);
        return ^(taps & gen);
    endfunction

endpackage

// File: rtl/fec_pingpong_buf.sv
// rtl/fec_pingpong_buf.sv - two-entry 96-bit ping-pong block buffer with full flags
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en_i, wr_data_i  accept one bit into the current write buffer
//   wr_ready_o          current write buffer is not full
//   rd_release_i        current read buffer has been consumed; free it
//   rd_full_o           current read buffer holds a complete block
//   rd_other_full_o     the buffer that becomes the read buffer after release is full
//   rd_data_o           contents of the current read buffer
module fec_pingpong_buf
    import wimax_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_i,
    input  logic                      wr_data_i,
    output logic                      wr_ready_o,
    input  logic                      rd_release_i,
    output logic                      rd_full_o,
    output logic                      rd_other_full_o,
    output logic [FEC_BLOCK_BITS-1:0] rd_data_o
);

    logic [FEC_BLOCK_BITS-1:0] mem_q [2];
    logic [1:0]                full_q;
    logic [1:0]                full_d;
    logic                      wr_ptr_q;
    logic                      rd_ptr_q;
    logic [6:0]                wr_cnt_q;
    logic                      wr_last;

    assign wr_last = (wr_cnt_q == 7'(FEC_BLOCK_BITS - 1));

    // Release and fill always target different buffers (a full buffer is never
    // written), so both updates are applied independently in one cycle.
    always_comb begin
        full_d = full_q;
        if (rd_release_i) begin
            full_d[rd_ptr_q] = 1'b0;
        end
        if (wr_en_i && wr_last) begin
            full_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            full_q <= full_d;
            if (wr_en_i) begin
                mem_q[wr_ptr_q][wr_cnt_q] <= wr_data_i;
                if (wr_last) begin
                    wr_cnt_q <= '0;
                    wr_ptr_q <= ~wr_ptr_q;
                end else begin
                    wr_cnt_q <= wr_cnt_q + 7'd1;
                end
            end
            if (rd_release_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign wr_ready_o      = ~full_q[wr_ptr_q];
    assign rd_full_o       = full_q[rd_ptr_q];
    assign rd_other_full_o = full_q[~rd_ptr_q];
    assign rd_data_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fec_encoder.sv
// rtl/fec_encoder.sv - rate-1/2 K=7 tail-biting convolutional encoder (171/133 octal)
// Ports:
//   clk, rst_n         50 MHz clock, asynchronous active-low reset
//   i_valid, i_data    randomized input bit stream
//   i_ready            encoder can accept a bit this cycle (0 while in reset)
//   o_valid, o_data    encoded bit stream, X then Y per input bit
//   o_ready            downstream accepts o_data this cycle
//   o_blk_cnt          count of fully transferred encoded blocks (FEC_BLOCK_CNT_EN only)
// Build option: FEC_BLOCK_CNT_EN adds o_blk_cnt and its counter.
module fec_encoder
    import wimax_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic        i_data,
    output logic        i_ready,
    output logic        o_valid,
    output logic        o_data,
    input  logic        o_ready
`ifdef FEC_BLOCK_CNT_EN
    ,
    output logic [15:0] o_blk_cnt
`endif
);

    fec_state_t                state_q, state_d;
    logic [6:0]                bit_idx_q, bit_idx_d;
    logic                      phase_q, phase_d;   // 0: emitting X, 1: emitting Y
    logic [5:0]                sr_q, sr_d;         // sr_q[5] = s1 ... sr_q[0] = s6
    logic                      wr_ready;
    logic                      rd_full;
    logic                      rd_other_full;
    logic                      rd_release;
    logic [FEC_BLOCK_BITS-1:0] rd_data;
    logic                      cur_bit;
    logic [FEC_K-1:0]          taps;

    assign i_ready = rst_n & wr_ready;

    fec_pingpong_buf u_buf (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en_i         (i_valid & i_ready),
        .wr_data_i       (i_data),
        .wr_ready_o      (wr_ready),
        .rd_release_i    (rd_release),
        .rd_full_o       (rd_full),
        .rd_other_full_o (rd_other_full),
        .rd_data_o       (rd_data)
    );

    assign cur_bit = rd_data[bit_idx_q];
    assign taps    = {cur_bit, sr_q};

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        phase_d    = phase_q;
        sr_d       = sr_q;
        rd_release = 1'b0;
        o_valid    = 1'b0;
        o_data     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_full) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                // Tail-biting: start from the block's own last six bits
                sr_d      = rd_data[FEC_BLOCK_BITS-1 -: 6];
                bit_idx_d = '0;
                phase_d   = 1'b0;
                state_d   = ENC;
            end
            ENC: begin
                o_valid = 1'b1;
                o_data  = phase_q ? fec_parity(taps, FEC_G2) : fec_parity(taps, FEC_G1);
                if (o_ready) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        sr_d    = {cur_bit, sr_q[5:1]};
                        if (bit_idx_q == 7'(FEC_BLOCK_BITS - 1)) begin
                            rd_release = 1'b1;
                            bit_idx_d  = '0;
                            // The other buffer becomes the read buffer after release
                            state_d    = rd_other_full ? INIT : IDLE;
                        end else begin
                            bit_idx_d = bit_idx_q + 7'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            phase_q   <= 1'b0;
            sr_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            phase_q   <= phase_d;
            sr_q      <= sr_d;
        end
    end

`ifdef FEC_BLOCK_CNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else if (rd_release) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign o_blk_cnt = blk_cnt_q;
`endif

endmodule

// File: doc/fec_encoder.md
FEC_ENCODER -- requirements
Module: fec_encoder

Interface
REQ-001 clk  input  1  system clock, 50 MHz.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 i_valid  input  1  randomized bit valid from prbs_randomizer.
REQ-004 i_data  input  1  randomized data bit.
REQ-005 i_ready  output  1  encoder can accept i_data this cycle.
REQ-006 o_valid  output  1  encoded bit valid, to interleaver.
REQ-007 o_data  output  1  encoded bit.
REQ-008 o_ready  input  1  downstream accepts o_data this cycle.

Function
REQ-009 The block SHALL be a rate-1/2 tail-biting convolutional encoder, K=7, G1=171 octal (X), G2=133 octal (Y), per IEEE 802.16-2007 8.4.9.2.1.
REQ-010 Input transfer SHALL occur on a rising clk edge with i_valid && i_ready; output transfer on o_valid && o_ready.
REQ-011 Input bits SHALL be grouped into 96-bit blocks, bit index 0 = first accepted, written into a two-entry ping-pong buffer.
REQ-012 A buffer SHALL be marked full on acceptance of its bit 95; the write pointer then moves to the other buffer.
REQ-013 i_ready SHALL be 1 iff the current write buffer is not full; both full -> i_ready=0.
REQ-014 Read FSM states: IDLE, INIT, ENC.
REQ-015 IDLE -> INIT when the current read buffer is full; INIT lasts exactly one cycle, o_valid=0.
REQ-016 INIT SHALL load the shift register s1..s6 with bits 95..90 of the read buffer (s1=bit95).
REQ-017 ENC SHALL emit 192 bits: for input bit b (index 0..95), X = b^s1^s2^s3^s6, then Y = b^s2^s3^s5^s6; shift register advances after Y is transferred.
REQ-018 o_data and o_valid SHALL hold stable while o_valid && !o_ready.
REQ-019 After output 191 transfers, the read buffer SHALL be released (not full), read pointer toggles; FSM -> INIT directly if the other buffer is full, else IDLE.
REQ-020 Latency: bit 95 accepted at edge N -> INIT during cycle N+1, first o_valid=1 at edge N+2 (read FSM idle, buffer empty beforehand).
REQ-021 Simultaneous release of a buffer and write of bit 95 into the other SHALL both take effect in the same cycle, no bubble lost, no data corrupted.
REQ-022 A buffer SHALL never be written while being read; partial blocks SHALL wait indefinitely.

Reset
REQ-023 rst_n low SHALL clear both buffers, full flags, pointers, bit counters and shift register; FSM=IDLE.
REQ-024 Output reset values: i_ready=1 after reset release (0 while rst_n low), o_valid=0, o_data=0.
REQ-025 Reset mid-block SHALL discard all partial and pending blocks; no encoded bit of a pre-reset block is emitted afterwards.

Configuration
REQ-026 Macro FEC_BLOCK_CNT_EN defined: extra output o_blk_cnt (16 bits) SHALL count fully transferred encoded blocks, wrapping 65535->0, reset 0.
REQ-027 Macro FEC_BLOCK_CNT_EN undefined: port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 wimax_pkg SHALL hold FEC_BLOCK_BITS=96, FEC_OUT_BITS=192, FEC_K=7, FEC_G1=7'o171, FEC_G2=7'o133, and typedef fec_state_t {IDLE, INIT, ENC}.
REQ-029 Ping-pong storage SHALL be sub-module fec_pingpong_buf (write port, read port, full flags); encoder FSM and shift register in fec_encoder.

Verification
REQ-030 96 zeros, o_ready=1 -> 192 zeros, first o_valid 2 cycles after bit 95.
REQ-031 96 ones -> 192 ones.
REQ-032 bit0=1, bits1..95=0 -> outputs 0..13 = 1,1,1,0,1,1,1,1,0,0,0,1,1,1; outputs 14..191 = 0.
REQ-033 Three back-to-back random blocks, o_ready=0 throughout -> i_ready drops after block 2 bit 95; release o_ready -> all 576 bits match golden model, block 3 then accepted.
REQ-034 o_ready toggled randomly -> o_data stable while stalled, output matches golden model bit-exact.
REQ-035 rst_n asserted after 50 bits of block 1 and mid-output of block 0 -> o_valid=0 immediately; fresh block after release encodes correctly; o_blk_cnt=0 (FEC_BLOCK_CNT_EN).
